// File: rtl/fpu_result_fifo_if.sv
// Handshake bundle between the fpu multiplier, the result FIFO and its consumer.
// The FIFO side uses the slave modport; the producer/consumer side uses master.
interface fpu_result_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [2:0]  out_class;

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_y, out_class
  );

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_y, out_class
  );
endinterface

// File: rtl/fpu_result_fifo.sv
// Result FIFO for the binary32 multiplier: classifies each accepted product and keeps sticky flags.
// Define FPU_STATS_EN to build the saturating NaN/inf counters; otherwise nan_cnt/inf_cnt read 0.
module fpu_result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_result_fifo_if.slave bus,
  output logic [LVL_W-1:0] level,
  output logic [3:0]       sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] inf_cnt
);

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fpuClass_e;

  logic [34:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [LVL_W-1:0] r_level;
  logic [3:0]       r_sticky;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_exp;
  logic [22:0]      w_frac;
  fpuClass_e        w_class;
  logic             w_isNan;
  logic             w_isInf;
  logic [3:0]       w_stickySet;
  logic [34:0]      w_head;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = bus.out_ready & ~w_empty;

  assign w_exp  = bus.in_y[30:23];
  assign w_frac = bus.in_y[22:0];

  // Sign bit plays no part; the quiet bit is frac[22].
  always_comb begin
    w_class = CLS_NORM;
    if (w_exp == 8'h00) begin
      w_class = (w_frac == '0) ? CLS_ZERO : CLS_SUB;
    end else if (w_exp == 8'hFF) begin
      if (w_frac == '0)
        w_class = CLS_INF;
      else if (w_frac[22])
        w_class = CLS_QNAN;
      else
        w_class = CLS_SNAN;
    end
  end

  assign w_isNan     = (w_class == CLS_QNAN) || (w_class == CLS_SNAN);
  assign w_isInf     = (w_class == CLS_INF);
  assign w_stickySet = w_push ? {w_isNan, w_isInf, (w_class == CLS_SUB), (w_class == CLS_ZERO)}
                              : 4'b0000;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= {w_class, bus.in_y};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sticky <= '0;
    else
      r_sticky <= (clr_sticky ? 4'b0000 : r_sticky) | w_stickySet;
  end

`ifdef FPU_STATS_EN
  logic [CNT_W-1:0] r_nanCnt;
  logic [CNT_W-1:0] r_infCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nanCnt <= '0;
      r_infCnt <= '0;
    end else if (clr_sticky) begin
      r_nanCnt <= '0;
      r_infCnt <= '0;
    end else begin
      if (w_push && w_isNan && (r_nanCnt != '1))
        r_nanCnt <= r_nanCnt + CNT_W'(1);
      if (w_push && w_isInf && (r_infCnt != '1))
        r_infCnt <= r_infCnt + CNT_W'(1);
    end
  end

  assign nan_cnt = r_nanCnt;
  assign inf_cnt = r_infCnt;
`else
  assign nan_cnt = '0;
  assign inf_cnt = '0;
`endif

  assign w_head        = r_mem[r_rdPtr];
  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_y     = w_empty ? 32'h0 : w_head[31:0];
  assign bus.out_class = w_empty ? 3'd0  : w_head[34:32];
  assign level         = r_level;
  assign sticky        = r_sticky;

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Self-checking bench for fpu_result_fifo: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_fpu_result_fifo;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clr_sticky;
  logic [LVL_W-1:0] level;
  logic [3:0]       sticky;
  logic [CNT_W-1:0] nan_cnt;
  logic [CNT_W-1:0] inf_cnt;

  fpu_result_fifo_if bus();

  fpu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .level      (level),
    .sticky     (sticky),
    .clr_sticky (clr_sticky),
    .nan_cnt    (nan_cnt),
    .inf_cnt    (inf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] y;
    logic        ordy;
    logic        clr;
    logic        eValid;
    logic [31:0] eY;
    logic [2:0]  eCls;
    logic [2:0]  eLvl;
    logic        eRdy;
    logic [3:0]  eSticky;
  } vec_t;

  vec_t        vecs [15];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] mQ [$];
  logic [3:0]  mSticky;
  int          mNan;
  int          mInf;

  // Classification straight from the binary32 field rules, using integer field values.
  function automatic logic [2:0] refClass(input logic [31:0] y);
    int e;
    int f;
    e = int'(y[30:23]);
    f = int'(y[22:0]);
    if (e == 0) return (f == 0) ? 3'd0 : 3'd1;
    if (e == 255) begin
      if (f == 0) return 3'd3;
      if (f >= 32'h0040_0000) return 3'd4;
      return 3'd5;
    end
    return 3'd2;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mQ.delete();
    mSticky = 4'b0000;
    mNan = 0;
    mInf = 0;
  endtask

  // One clock cycle of stimulus; the model advances with the same handshake rules.
  task automatic applyStimulus(input logic iv, input logic [31:0] y, input logic ordy, input logic clr);
    bit       doPush;
    bit       doPop;
    logic [2:0] cls;
    logic [3:0] newBits;
    bus.in_valid  = iv;
    bus.in_y      = y;
    bus.out_ready = ordy;
    clr_sticky    = clr;
    doPush = iv && (mQ.size() < DEPTH);
    doPop  = ordy && (mQ.size() > 0);
    @(posedge clk);
    if (doPop) void'(mQ.pop_front());
    if (doPush) mQ.push_back(y);
    cls = refClass(y);
    newBits = 4'b0000;
    if (doPush) begin
      case (cls)
        3'd0:    newBits = 4'b0001;
        3'd1:    newBits = 4'b0010;
        3'd3:    newBits = 4'b0100;
        3'd4, 3'd5: newBits = 4'b1000;
        default: newBits = 4'b0000;
      endcase
    end
    mSticky = (clr ? 4'b0000 : mSticky) | newBits;
    if (clr) begin
      mNan = 0;
      mInf = 0;
    end else if (doPush) begin
      if (newBits[3] && mNan < CNT_MAX) mNan++;
      if (newBits[2] && mInf < CNT_MAX) mInf++;
    end
    #1;
  endtask

  task automatic checkOutput();
    int expNan;
    int expInf;
    expNan = 0;
    expInf = 0;
`ifdef FPU_STATS_EN
    expNan = mNan;
    expInf = mInf;
`endif
    checkValue("out_valid", 32'(bus.out_valid), 32'(mQ.size() > 0));
    checkValue("out_y", bus.out_y, (mQ.size() > 0) ? mQ[0] : 32'h0);
    checkValue("out_class", 32'(bus.out_class), (mQ.size() > 0) ? 32'(refClass(mQ[0])) : 32'h0);
    checkValue("level", 32'(level), 32'(mQ.size()));
    checkValue("in_ready", 32'(bus.in_ready), 32'(mQ.size() < DEPTH));
    checkValue("sticky", 32'(sticky), 32'(mSticky));
    checkValue("nan_cnt", 32'(nan_cnt), 32'(expNan));
    checkValue("inf_cnt", 32'(inf_cnt), 32'(expInf));
  endtask

  function automatic logic [31:0] pickValue();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v = {v[31], 31'h0};
      1: v = {v[31], 8'h00, (v[22:0] == '0) ? 23'h1 : v[22:0]};
      2: v = {v[31], 8'hFF, 23'h0};
      3: v = {v[31], 8'hFF, 1'b1, v[21:0]};
      4: v = {v[31], 8'hFF, 1'b0, (v[21:0] == '0) ? 22'h1 : v[21:0]};
      default: v = v;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] v;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_y      = 32'h0;
    bus.out_ready = 1'b0;
    clr_sticky    = 1'b0;
    resetModel();

    vecs[0]  = '{1'b1, 32'h40400000, 1'b0, 1'b0, 1'b1, 32'h40400000, 3'd2, 3'd1, 1'b1, 4'b0000};
    vecs[1]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 3'd0, 1'b1, 4'b0000};
    vecs[2]  = '{1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b1, 32'h7F800000, 3'd3, 3'd1, 1'b1, 4'b0100};
    vecs[3]  = '{1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 32'h7F800000, 3'd3, 3'd2, 1'b1, 4'b1100};
    vecs[4]  = '{1'b1, 32'h7F800001, 1'b0, 1'b0, 1'b1, 32'h7F800000, 3'd3, 3'd3, 1'b1, 4'b1100};
    vecs[5]  = '{1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7F800000, 3'd3, 3'd4, 1'b0, 4'b1110};
    vecs[6]  = '{1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h7F800000, 3'd3, 3'd4, 1'b0, 4'b1110};
    vecs[7]  = '{1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 3'd4, 3'd3, 1'b1, 4'b1110};
    vecs[8]  = '{1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 3'd4, 3'd4, 1'b0, 4'b1111};
    vecs[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h7F800001, 3'd5, 3'd3, 1'b1, 4'b1111};
    vecs[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000001, 3'd1, 3'd2, 1'b1, 4'b1111};
    vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h80000000, 3'd0, 3'd1, 1'b1, 4'b1111};
    vecs[12] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 3'd0, 1'b1, 4'b1111};
    vecs[13] = '{1'b1, 32'h7FC00000, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 3'd4, 3'd1, 1'b1, 4'b1000};
    vecs[14] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 3'd0, 1'b1, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].y, vecs[i].ordy, vecs[i].clr);
      checkValue($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].eValid));
      checkValue($sformatf("vec%0d out_y", i), bus.out_y, vecs[i].eY);
      checkValue($sformatf("vec%0d out_class", i), 32'(bus.out_class), 32'(vecs[i].eCls));
      checkValue($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].eLvl));
      checkValue($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].eRdy));
      checkValue($sformatf("vec%0d sticky", i), 32'(sticky), 32'(vecs[i].eSticky));
    end
    checkOutput();

    // Hold level at 2 with push+pop every cycle long enough to wrap both pointers.
    applyStimulus(1'b1, 32'h3F800000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC0000000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, pickValue(), 1'b1, 1'b0);
      checkValue("steady level", 32'(level), 32'd2);
      checkOutput();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput();

    for (int i = 0; i < 500; i++) begin
      v = pickValue();
      applyStimulus(($urandom_range(0, 9) < 6), v, ($urandom_range(0, 9) < ((i / 50) % 2 == 0 ? 3 : 7)),
                    ($urandom_range(0, 63) == 0));
      checkOutput();
    end

    // Asynchronous reset with three entries stored, asserted between clock edges.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h7F800000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7FA00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00400000, 1'b0, 1'b0);
    checkValue("pre-reset level", 32'(level), 32'd3);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 32'h40400000, 1'b0, 1'b0);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
